mul_div_unit: RTL and testbench

//  Multi-cycle RV32M execute unit beside the integer ALU in EX; consumes the same DATA1/DATA2 operands.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_div_core.sv | 86 ++++++++
 rtl/mul_div_unit.sv | 186 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg: shared definitions for the RV32M multiply/divide unit.
//   - MDU_OP_* : funct3 encodings of the eight M-extension operations
//   - mdu_state_e : control FSM states (IDLE, CALC, FIX, FIN)
//   - DIV0_QUOT / INT_MIN : XLEN-wide boundary constants
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } mdu_state_e;

    localparam logic [MDU_XLEN-1:0] DIV0_QUOT = {MDU_XLEN{1'b1}};
    localparam logic [MDU_XLEN-1:0] INT_MIN   = {1'b1, {(MDU_XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_div_core.sv
// -----------------------------------------------------------------------------
// mdu_div_core: restoring-divide step datapath on unsigned magnitudes, plus
// the shared iteration counter (the multiply path in the parent reuses it).
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : capture dividend/divisor, clear remainder and counter
//   step_i         : advance the counter by one iteration
//   div_en_i       : also perform one shift-subtract step this iteration
//   dividend_i     : dividend magnitude
//   divisor_i      : divisor magnitude
//   quot_o, rem_o  : unsigned quotient / remainder after DIV_ITERS steps
//   last_o         : counter is on its final iteration
// -----------------------------------------------------------------------------
module mdu_div_core #(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            div_en_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o,
    output logic            last_o
);

    localparam int CW = $clog2(DIV_ITERS + 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // quot_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder each step while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {1'b0, dvsr_q};
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        if (load_i) begin
            cnt_d  = '0;
            quot_d = dividend_i;
            rem_d  = '0;
            dvsr_d = divisor_i;
        end else if (step_i) begin
            cnt_d = cnt_q + CW'(1);
            if (div_en_i) begin
                if (diff[XLEN]) begin
                    // Trial subtract went negative: restore.
                    rem_d  = shifted[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_d  = diff[XLEN-1:0];
                    quot_d = {quot_q[XLEN-2:0], 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CW'(DIV_ITERS - 1));

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/
// DIV/DIVU/REM/REMU). Works on operand magnitudes and applies the sign in FIX.
// Ports:
//   CLK, RESET   : clock, synchronous active-high reset
//   START        : request, honoured only while BUSY=0
//   FLUSH        : abort any in-flight operation, no DONE, RESULT kept
//   MDU_OP       : funct3 operation select
//   DATA1, DATA2 : rs1 / rs2 operands, captured when START is accepted
//   BUSY         : high in CALC, FIX and FIN
//   DONE         : one-cycle pulse, RESULT valid
//   RESULT       : registered result, held until the next DONE
// Optional feature macro MDU_FAST_MUL_EN: single-cycle 33x33 multiplier for
// the MUL* ops (DONE one edge after acceptance); divide path unchanged.
// XLEN must stay 32 (package constants) and DIV_ITERS must equal XLEN.
// -----------------------------------------------------------------------------
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      MDU_OP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    mdu_state_e state_q, state_d;

    logic              accept, step, do_fix, finish;
    logic              a_signed, b_signed, sa, sb;
    logic              div_by_zero, overflow, special, fast;
    logic [XLEN-1:0]   mag1, mag2, special_res, fast_res;

    logic [2:0]        op_q;
    logic              sa_q, sb_q;
    logic [XLEN-1:0]   a_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   res_q, result_q;
    logic              done_q;

    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix, fix_res;
    logic              div_last;

    // Operand decode on the request inputs (only used at acceptance).
    always_comb begin
        a_signed = (MDU_OP == MDU_OP_MULH) || (MDU_OP == MDU_OP_MULHSU) ||
                   (MDU_OP == MDU_OP_DIV)  || (MDU_OP == MDU_OP_REM);
        b_signed = (MDU_OP == MDU_OP_MULH) || (MDU_OP == MDU_OP_DIV) ||
                   (MDU_OP == MDU_OP_REM);
        sa   = a_signed & DATA1[XLEN-1];
        sb   = b_signed & DATA2[XLEN-1];
        // INT_MIN negates to itself, which is still its correct magnitude.
        mag1 = sa ? -DATA1 : DATA1;
        mag2 = sb ? -DATA2 : DATA2;

        div_by_zero = MDU_OP[2] && (DATA2 == '0);
        overflow    = ((MDU_OP == MDU_OP_DIV) || (MDU_OP == MDU_OP_REM)) &&
                      (DATA1 == INT_MIN) && (DATA2 == DIV0_QUOT);
        special     = div_by_zero || overflow;
        if (div_by_zero) special_res = MDU_OP[1] ? DATA1 : DIV0_QUOT;
        else             special_res = MDU_OP[1] ? '0 : INT_MIN;
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fprod;
    always_comb begin
        fast     = !MDU_OP[2];
        fa       = {a_signed & DATA1[XLEN-1], DATA1};
        fb       = {b_signed & DATA2[XLEN-1], DATA2};
        fprod    = fa * fb;
        fast_res = (MDU_OP == MDU_OP_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    // Control FSM next state. FLUSH forces IDLE and drops a same-cycle START.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        do_fix  = 1'b0;
        finish  = 1'b0;
        if (FLUSH) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    accept  = 1'b1;
                    state_d = (special || fast) ? FIN : CALC;
                end
                CALC: begin
                    step = 1'b1;
                    if (div_last) state_d = FIX;
                end
                FIX: begin
                    do_fix  = 1'b1;
                    state_d = FIN;
                end
                FIN: begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Shift-add multiply step: add the multiplicand into the high half when
    // the multiplier LSB (low half) is set, then shift the whole pair right.
    assign sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);

    // Sign fix-up and word selection.
    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
        quot_fix = (sa_q ^ sb_q) ? -quot : quot;
        rem_fix  = sa_q ? -rem : rem;
        if (op_q[2])               fix_res = op_q[1] ? rem_fix : quot_fix;
        else if (op_q[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
        else                       fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    mdu_div_core #(
        .XLEN      (XLEN),
        .DIV_ITERS (DIV_ITERS)
    ) u_div_core (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (accept),
        .step_i     (step),
        .div_en_i   (op_q[2]),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .quot_o     (quot),
        .rem_o      (rem),
        .last_o     (div_last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (finish) result_q <= res_q;
            if (accept) begin
                op_q   <= MDU_OP;
                sa_q   <= sa;
                sb_q   <= sb;
                a_q    <= mag1;
                prod_q <= {{XLEN{1'b0}}, mag2};
                if (special)   res_q <= special_res;
                else if (fast) res_q <= fast_res;
            end else if (step && !op_q[2]) begin
                prod_q <= {sum, prod_q[XLEN-1:1]};
            end else if (do_fix) begin
                res_q <= fix_res;
            end
        end
    end

    assign BUSY   = (state_q != IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit: directed and random checks of mul_div_unit against an
// arithmetic reference model (64-bit integer math on the RV32M rules).
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [2:0]  MDU_OP;
    logic [31:0] DATA1, DATA2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    mul_div_unit #(.XLEN(32), .DIV_ITERS(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FLUSH  (FLUSH),
        .MDU_OP (MDU_OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint    sa, sb, su, p;
        logic [63:0] ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        su = longint'({32'b0, b});
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            OP_MUL:    begin pu = ua * ub; return pu[31:0];  end
            OP_MULH:   begin p = sa * sb;  return p[63:32];  end
            OP_MULHSU: begin p = sa * su;  return p[63:32];  end
            OP_MULHU:  begin pu = ua * ub; return pu[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            OP_DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub;
                return pu[31:0];
            end
            OP_REM:    begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default:   begin
                if (b == 0) return a;
                pu = ua % ub;
                return pu[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
`ifdef MDU_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 34;
    endfunction

    // ---------------- driver ----------------
    // Issues one operation, optionally pokes START again at edge poke_edge
    // while busy, and checks latency, BUSY, RESULT and the DONE pulse width.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int poke_edge);
        int lat, want_lat, busy_gaps;
        logic [31:0] want;
        exp_q.push_back(ref_mdu(op, a, b));
        want_lat = exp_latency(op, a, b);
        @(negedge CLK);
        START = 1'b1; MDU_OP = op; DATA1 = a; DATA2 = b;
        @(posedge CLK); #1;
        START = 1'b0;
        chk({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
        lat = 0;
        busy_gaps = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == poke_edge) begin
                START = 1'b1; MDU_OP = OP_MUL; DATA1 = 32'd3; DATA2 = 32'd5;
            end
            @(posedge CLK); #1;
            START = 1'b0;
            if (DONE === 1'b1) begin
                lat = k;
                break;
            end
            if (BUSY !== 1'b1) busy_gaps++;
        end
        want = exp_q.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(want_lat));
        chk({tag, "_busy_gap"}, 32'(busy_gaps), 32'd0);
        chk({tag, "_result"}, RESULT, want);
        chk({tag, "_idle_at_done"}, {31'b0, BUSY}, 32'd0);
        last_res = want;
        @(posedge CLK); #1;
        chk({tag, "_pulse"}, {31'b0, DONE}, 32'd0);
        chk({tag, "_hold"}, RESULT, want);
    endtask

    task automatic watch_quiet(input string tag, input logic [31:0] want_res);
        int dones;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (DONE !== 1'b0) dones++;
        end
        chk({tag, "_no_done"}, 32'(dones), 32'd0);
        chk({tag, "_busy"}, {31'b0, BUSY}, 32'd0);
        chk({tag, "_result"}, RESULT, want_res);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int mode;

        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        MDU_OP = 3'b0; DATA1 = 32'b0; DATA2 = 32'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", {31'b0, BUSY}, 32'd0);
        chk("reset_done", {31'b0, DONE}, 32'd0);
        chk("reset_result", RESULT, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Directed arithmetic and boundary cases.
        run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, "mul_7_m3", 0);
        chk("mul_7_m3_value", last_res, 32'hFFFF_FFEB);
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff", 0);
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff", 0);
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff", 0);
        run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         "div_m7_2", 0);
        run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         "rem_m7_2", 0);
        run_op(OP_DIVU,   32'd100,       32'd7,         "divu_100_7", 0);
        run_op(OP_REMU,   32'd100,       32'd7,         "remu_100_7", 0);
        run_op(OP_DIV,    32'd5,         32'd0,         "div_by0", 0);
        run_op(OP_REM,    32'd5,         32'd0,         "rem_by0", 0);
        run_op(OP_DIVU,   32'd5,         32'd0,         "divu_by0", 0);
        run_op(OP_REMU,   32'hDEAD_BEEF, 32'd0,         "remu_by0", 0);
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0);
        run_op(OP_MUL,    32'h8000_0000, 32'hFFFF_FFFF, "mul_intmin", 0);
        run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_intmin", 0);
        run_op(OP_REM,    32'd7,         32'hFFFF_FFFE, "rem_7_m2", 0);

        // START while busy is ignored: result must be the DIVU, not the poke.
        run_op(OP_DIVU, 32'd1000, 32'd9, "start_while_busy", 3);

        // FLUSH at edge 10 of a DIVU.
        @(negedge CLK);
        START = 1'b1; MDU_OP = OP_DIVU; DATA1 = 32'd12345; DATA2 = 32'd11;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge CLK); #1;
        end
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        chk("flush_busy_now", {31'b0, BUSY}, 32'd0);
        watch_quiet("flush", last_res);

        // FLUSH and START together in IDLE: request dropped.
        @(negedge CLK);
        START = 1'b1; FLUSH = 1'b1; MDU_OP = OP_DIV; DATA1 = 32'd9; DATA2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        chk("flush_start_busy", {31'b0, BUSY}, 32'd0);
        watch_quiet("flush_start", last_res);

        // Next START after a flush executes normally.
        run_op(OP_DIVU, 32'd100, 32'd7, "after_flush", 0);

        // RESET at edge 5 of a DIV, with an extra START at edge 2 while busy.
        @(negedge CLK);
        START = 1'b1; MDU_OP = OP_DIV; DATA1 = 32'hFFFF_FF9C; DATA2 = 32'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin
                START = 1'b1; MDU_OP = OP_MULHU; DATA1 = 32'd77; DATA2 = 32'd88;
            end
            @(posedge CLK); #1;
            START = 1'b0;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("midreset_busy", {31'b0, BUSY}, 32'd0);
        chk("midreset_done", {31'b0, DONE}, 32'd0);
        chk("midreset_result", RESULT, 32'd0);
        RESET = 1'b0;
        last_res = 32'd0;
        watch_quiet("midreset", 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b, "rnd", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
